// File: rtl/mesh_term_src_if.sv
// Terminal-source bundle: environment write side plus router
// pndng/data/pop side and status.
interface mesh_term_src_if #(
  parameter int PCKG_SZ = 40,
  parameter int DEPTH   = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               push;
  logic [PCKG_SZ-1:0] data_in;
  logic               full;
  logic [CW-1:0]      count;
  logic               popin;
  logic               pndng;
  logic [PCKG_SZ-1:0] data_out;
  logic               overflow;
  logic               underflow;
  logic [15:0]        sent_cnt;

  modport master (
    output push, data_in, popin,
    input  full, count, pndng, data_out,
    input  overflow, underflow, sent_cnt
  );

  modport slave (
    input  push, data_in, popin,
    output full, count, pndng, data_out,
    output overflow, underflow, sent_cnt
  );
endinterface

// File: rtl/mesh_term_src.sv
// Terminal-side packet source: FWFT FIFO feeding one mesh
// router input port over the pndng/data/pop handshake.
module mesh_term_src #(
  parameter int PCKG_SZ = 40,
  parameter int DEPTH   = 8,
  parameter int ID      = 0
) (
  input logic           clk,
  input logic           reset,
  mesh_term_src_if.slave t
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [PCKG_SZ-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_q, rd_d;
  logic [AW-1:0]      wr_q, wr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [15:0]        sent_q, sent_d;
  logic               full, pndng;
  logic               pop_ok, push_ok;

  assign pndng   = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = t.popin && pndng;
  // A full FIFO still takes a push when the head leaves this cycle
  assign push_ok = t.push && (!full || pop_ok);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    sent_d  = sent_q;
    if (pop_ok) begin
      rd_d   = rd_q + AW'(1);
      sent_d = sent_q + 16'd1;
    end
    if (push_ok)
      wr_d = wr_q + AW'(1);
    if (push_ok && !pop_ok)
      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok)
      count_d = count_q - CW'(1);
    if (t.push && !push_ok)
      ovf_d = 1'b1;
    if (t.popin && !pndng)
      unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      sent_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      sent_q  <= sent_d;
    end
  end

  // Storage is deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_q] <= t.data_in;
  end

  assign t.full      = full;
  assign t.count     = count_q;
  assign t.pndng     = pndng;
  assign t.data_out  = pndng ? mem_q[rd_q] : '0;
  assign t.overflow  = ovf_q;
  assign t.underflow = unf_q;
  assign t.sent_cnt  = sent_q;
endmodule
